// File: rtl/bs_loader.sv
// Sorted-array writer: inserts one value per Start/Done handshake into a
// 32-entry ascending array, one compare-and-shift step per clock.
module bs_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] A,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   Count,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow
);

  localparam int            DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [DATA_W-1:0]  a_q_r;
  logic [ADDR_W:0]    pos_r;
  logic [ADDR_W:0]    count_r;
  logic               ovf_r;

  logic [ADDR_W-1:0]  hole_s;
  logic [ADDR_W-1:0]  prev_addr_s;
  logic [DATA_W-1:0]  prev_s;
  logic               full_s;
  logic               shift_s;

  // Strict compare keeps equal values in arrival order.
  assign hole_s      = pos_r[ADDR_W-1:0];
  assign prev_addr_s = hole_s - ONE_ADDR;
  assign prev_s      = mem_r[prev_addr_s];
  assign full_s      = (count_r == FULL_CNT);
  assign shift_s     = (pos_r != {(ADDR_W+1){1'b0}}) && (prev_s > a_q_r);

  assign rd_data  = mem_r[rd_addr];
  assign Count    = count_r;
  assign Busy     = (state_r == S_SHIFT);
  assign Done     = (state_r == S_DONE);
  assign Overflow = ovf_r;

  // Next-state decode for the insertion handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          if (full_s) begin
            state_s = S_DONE;
          end else begin
            state_s = S_SHIFT;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (shift_s) begin
          state_s = S_SHIFT;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE: begin
        if (!Start) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State, array and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r <= S_IDLE;
      a_q_r   <= {DATA_W{1'b0}};
      pos_r   <= {(ADDR_W+1){1'b0}};
      count_r <= {(ADDR_W+1){1'b0}};
      ovf_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_r <= state_s;
      case (state_r)
        S_IDLE: begin
          if (Start) begin
            if (full_s) begin
              ovf_r <= 1'b1;
            end else begin
              a_q_r <= A;
              pos_r <= count_r;
            end
          end
        end
        S_SHIFT: begin
          if (shift_s) begin
            mem_r[hole_s] <= prev_s;
            pos_r         <= pos_r - ONE_CNT;
          end else begin
            mem_r[hole_s] <= a_q_r;
            count_r       <= count_r + ONE_CNT;
            ovf_r         <= 1'b0;
          end
        end
        S_DONE: begin
          if (!Start) begin
            ovf_r <= 1'b0;
          end
        end
        default: begin
          ovf_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bs_loader.sv
// Directed bench for bs_loader: hand-computed latencies, array contents,
// overflow, held-Start and mid-shift reset behaviour.
module tb_bs_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [5:0] count;
  logic       busy;
  logic       done;
  logic       overflow;

  int total_cnt = 0;
  int bad_cnt   = 0;

  bs_loader #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk      (clk),
    .Reset    (reset),
    .Start    (start),
    .A        (a),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .Count    (count),
    .Busy     (busy),
    .Done     (done),
    .Overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_rd(input int addr, input int exp);
    rd_addr = addr[4:0];
    #1;
    check_eq($sformatf("arr[%0d]", addr), {24'd0, rd_data}, exp[31:0]);
  endtask

  // Full handshake; lat counts edges after acceptance until Done is seen.
  task automatic insert(input int val, input int exp_lat, input logic exp_ovf);
    int lat;
    int busy_n;
    lat = 0;
    busy_n = 0;
    @(negedge clk);
    start = 1'b1;
    a = val[7:0];
    @(posedge clk);
    #1;
    a = ~val[7:0];
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_n++;
      if (done) break;
    end
    check_eq($sformatf("lat(%0d)", val), lat, exp_lat);
    check_eq($sformatf("ovf(%0d)", val), {31'd0, overflow}, {31'd0, exp_ovf});
    check_eq($sformatf("busy(%0d)", val), busy_n, exp_lat - 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq($sformatf("done_drop(%0d)", val), {31'd0, done}, 32'd0);
    check_eq($sformatf("ovf_drop(%0d)", val), {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = 8'd0;
    rd_addr = 5'd0;
    do_reset();
    #1;
    check_eq("rst_count", {26'd0, count}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_rd(0, 0);

    // 50, 10, 30
    insert(50, 1, 1'b0);
    insert(10, 2, 1'b0);
    insert(30, 2, 1'b0);
    check_rd(0, 10);
    check_rd(1, 30);
    check_rd(2, 50);
    check_eq("count3", {26'd0, count}, 32'd3);

    // 31 down to 0: worst-case shifting
    do_reset();
    for (int v = 31; v >= 0; v--) begin
      insert(v, 32 - v, 1'b0);
    end
    for (int i = 0; i < 32; i++) begin
      check_rd(i, i);
    end
    check_eq("count32", {26'd0, count}, 32'd32);

    // full reject
    insert(7, 1, 1'b1);
    check_eq("count_full", {26'd0, count}, 32'd32);
    check_rd(0, 0);
    check_rd(7, 7);
    check_rd(31, 31);

    // duplicates
    do_reset();
    insert(20, 1, 1'b0);
    insert(20, 1, 1'b0);
    insert(20, 1, 1'b0);
    insert(15, 4, 1'b0);
    check_rd(0, 15);
    check_rd(1, 20);
    check_rd(2, 20);
    check_rd(3, 20);
    check_eq("count4", {26'd0, count}, 32'd4);

    // Start held across Done
    @(negedge clk);
    start = 1'b1;
    a = 8'd25;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check_eq("hold_done", {31'd0, done}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check_eq("hold_count", {26'd0, count}, 32'd5);
    check_eq("hold_done_still", {31'd0, done}, 32'd1);
    check_eq("hold_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("hold_count_after", {26'd0, count}, 32'd5);
    check_rd(4, 25);

    // reset mid-shift
    do_reset();
    insert(10, 1, 1'b0);
    insert(20, 1, 1'b0);
    insert(30, 1, 1'b0);
    insert(40, 1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a = 8'd5;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    check_eq("mr_count", {26'd0, count}, 32'd0);
    check_eq("mr_busy", {31'd0, busy}, 32'd0);
    check_eq("mr_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_rd(i, 0);
    end
    insert(9, 1, 1'b0);
    check_rd(0, 9);
    check_eq("mr_count1", {26'd0, count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
